// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART encodings and baud helper
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } tx_state_t;

  function automatic int calc_bps_cnt(input int sys_clk_fre, input int bps);
    return sys_clk_fre / bps;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - synchronous FIFO with registered full/empty/level
module uart_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_wr_en,
  input  logic [DATA_W-1:0]            i_wr_data,
  input  logic                         i_rd_en,
  output logic [DATA_W-1:0]            o_rd_data,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_level
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic              r_full;
  logic              r_empty;
  logic              w_push;
  logic              w_pop;

  assign w_push = i_wr_en && !r_full;
  assign w_pop  = i_rd_en && !r_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // Flags are derived from the pre-edge level so they stay registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop) begin
        r_level <= r_level + LW'(1);
        r_empty <= 1'b0;
        r_full  <= (r_level == LW'(DEPTH - 1));
      end else if (!w_push && w_pop) begin
        r_level <= r_level - LW'(1);
        r_full  <= 1'b0;
        r_empty <= (r_level == LW'(1));
      end
    end
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_full    = r_full;
  assign o_empty   = r_empty;
  assign o_level   = r_level;

endmodule

// File: rtl/uart_tx_stream.sv
// rtl/uart_tx_stream.sv - FIFO-buffered UART transmitter with back-to-back frames
module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int SYS_CLK_FRE = 50_000_000,
  parameter int BPS         = 9_600,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                               sys_clk,
  input  logic                               sys_rst_n,
  input  logic [DATA_BITS-1:0]               uart_data,
  input  logic                               uart_tx_valid,
  output logic                               uart_tx_ready,
  output logic                               uart_txd,
  output logic                               tx_busy,
  output logic                               tx_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);
  localparam int BPS_CNT = calc_bps_cnt(SYS_CLK_FRE, BPS);
  localparam int CW      = $clog2(BPS_CNT);
  localparam int LW      = $clog2(FIFO_DEPTH + 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $fatal(1, "uart_tx_stream: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $fatal(1, "uart_tx_stream: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "uart_tx_stream: FIFO_DEPTH must be a power of two >= 2");
  end
  if (BPS_CNT < 4) begin : g_bad_bps
    $fatal(1, "uart_tx_stream: SYS_CLK_FRE/BPS must be >= 4");
  end

  tx_state_t             r_state;
  tx_state_t             w_state_nxt;
  logic [CW-1:0]         r_clk_cnt;
  logic [CW-1:0]         w_clk_cnt_nxt;
  logic [3:0]            r_bit_cnt;
  logic [3:0]            w_bit_cnt_nxt;
  logic [DATA_BITS-1:0]  r_shift;
  logic                  r_par;
  logic                  r_txd;
  logic                  r_busy;
  logic                  r_done;
  logic                  w_pop;
  logic                  w_done;
  logic                  w_txd_nxt;
  logic                  w_bit_end;
  logic                  w_full;
  logic                  w_empty;
  logic [DATA_BITS-1:0]  w_head;
  logic [LW-1:0]         w_level;

  uart_sync_fifo #(
    .DATA_W (DATA_BITS),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (sys_clk),
    .i_rst_n   (sys_rst_n),
    .i_wr_en   (uart_tx_valid),
    .i_wr_data (uart_data),
    .i_rd_en   (w_pop),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_level   (w_level)
  );

  assign w_bit_end = (r_clk_cnt == CW'(BPS_CNT - 1));

  always_comb begin
    w_state_nxt   = r_state;
    w_clk_cnt_nxt = '0;
    w_bit_cnt_nxt = r_bit_cnt;
    w_pop         = 1'b0;
    w_done        = 1'b0;
    w_txd_nxt     = 1'b1;
    if (r_state != ST_IDLE && !w_bit_end) w_clk_cnt_nxt = r_clk_cnt + CW'(1);
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        w_txd_nxt = 1'b0;
        if (w_bit_end) begin
          w_state_nxt   = ST_DATA;
          w_bit_cnt_nxt = '0;
        end
      end
      ST_DATA: begin
        w_txd_nxt = r_shift[0];
        if (w_bit_end) begin
          if (r_bit_cnt == 4'(DATA_BITS - 1)) begin
            w_bit_cnt_nxt = '0;
            w_state_nxt   = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          end
        end
      end
      ST_PAR: begin
        w_txd_nxt = r_par;
        if (w_bit_end) w_state_nxt = ST_STOP;
      end
      ST_STOP: begin
        if (w_bit_end) begin
          if (r_bit_cnt == 4'(STOP_BITS - 1)) begin
            w_done        = 1'b1;
            w_bit_cnt_nxt = '0;
            // Chain straight into the next start bit when more words are queued.
            if (!w_empty) begin
              w_pop       = 1'b1;
              w_state_nxt = ST_START;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Line outputs are registered from the current state, so they trail it by one clock.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state   <= ST_IDLE;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_txd     <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_clk_cnt <= w_clk_cnt_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_txd     <= w_txd_nxt;
      r_busy    <= (r_state != ST_IDLE);
      r_done    <= w_done;
      if (w_pop) begin
        r_shift <= w_head;
        r_par   <= (PARITY == PAR_ODD) ? ~^w_head : ^w_head;
      end else if (r_state == ST_DATA && w_bit_end) begin
        r_shift <= r_shift >> 1;
      end
    end
  end

  assign uart_txd      = r_txd;
  assign tx_busy       = r_busy;
  assign tx_done       = r_done;
  assign uart_tx_ready = !w_full;
  assign fifo_level    = w_level;

endmodule

// File: tb/tb_uart_tx_stream.sv
// tb/tb_uart_tx_stream.sv - randomized model-checked bench for uart_tx_stream
module tb_uart_tx_stream;
  localparam int CLKS  = 10;
  localparam int DB    = 8;
  localparam int PAR   = 2;
  localparam int SB    = 2;
  localparam int DEPTH = 4;
  localparam int NBITS = 1 + DB + ((PAR != 0) ? 1 : 0) + SB;
  localparam int FL    = NBITS * CLKS;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic [DB-1:0] data    = '0;
  logic          valid   = 1'b0;
  logic          ready, txd, busy, done;
  logic [2:0]    level;
  logic [6:0]    data_b  = '0;
  logic          valid_b = 1'b0;
  logic          ready_b, txd_b, busy_b, done_b;
  logic [2:0]    level_b;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  uart_tx_stream #(
    .SYS_CLK_FRE (1_000_000), .BPS (100_000), .DATA_BITS (DB),
    .PARITY (PAR), .STOP_BITS (SB), .FIFO_DEPTH (DEPTH)
  ) dut (
    .sys_clk (clk), .sys_rst_n (rst_n), .uart_data (data), .uart_tx_valid (valid),
    .uart_tx_ready (ready), .uart_txd (txd), .tx_busy (busy), .tx_done (done),
    .fifo_level (level)
  );

  uart_tx_stream #(
    .SYS_CLK_FRE (1_000_000), .BPS (100_000), .DATA_BITS (7),
    .PARITY (1), .STOP_BITS (1), .FIFO_DEPTH (4)
  ) dut_b (
    .sys_clk (clk), .sys_rst_n (rst_n), .uart_data (data_b), .uart_tx_valid (valid_b),
    .uart_tx_ready (ready_b), .uart_txd (txd_b), .tx_busy (busy_b), .tx_done (done_b),
    .fifo_level (level_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Frame bit idx of word w: start, data LSB first, optional parity, stop bits.
  function automatic logic frame_bit(input int w, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= DB) return w[idx-1];
    if (PAR != 0 && idx == DB + 1) return (PAR == 1) ? ~^w[DB-1:0] : ^w[DB-1:0];
    return 1'b1;
  endfunction

  int         q[$];
  bit         m_act  = 1'b0;
  int         m_clk  = 0;
  int         m_word = 0;
  bit         m_push;
  logic       e_txd = 1'b1, e_busy = 1'b0, e_done = 1'b0, e_ready = 1'b1;
  logic [2:0] e_level = '0;
  bit         chk_en = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_act = 1'b0; m_clk = 0;
      e_txd = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_ready = 1'b1; e_level = '0;
    end else begin
      m_push = valid && (q.size() < DEPTH);
      e_txd  = m_act ? frame_bit(m_word, m_clk / CLKS) : 1'b1;
      e_busy = m_act;
      e_done = m_act && (m_clk == FL - 1);
      if (m_act && m_clk != FL - 1) m_clk++;
      else if (q.size() != 0) begin
        m_word = q.pop_front(); m_act = 1'b1; m_clk = 0;
      end else m_act = 1'b0;
      if (m_push) q.push_back(int'(data));
      e_level = 3'(q.size());
      e_ready = (q.size() < DEPTH);
    end
  end

  always @(negedge clk) begin
    if (chk_en)
      check("outputs{txd,busy,done,ready,level}", {25'd0, txd, busy, done, ready, level},
            {25'd0, e_txd, e_busy, e_done, e_ready, e_level});
  end

  task automatic send_capture(input bit sel, input logic [8:0] w, input int nbits,
                              output logic [15:0] bits, output int lat, output int lvl,
                              output int done_cyc, output int done_cnt,
                              output logic busy_start, output logic busy_after);
    bits = '0; done_cyc = -1; done_cnt = 0; busy_after = 1'b1;
    @(negedge clk);
    if (sel) begin valid_b = 1'b1; data_b = w[6:0]; end
    else begin valid = 1'b1; data = w[7:0]; end
    @(negedge clk);
    valid = 1'b0; valid_b = 1'b0;
    lvl = sel ? int'(level_b) : int'(level);
    lat = 0;
    while ((sel ? txd_b : txd) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    busy_start = sel ? busy_b : busy;
    for (int c = 0; c < nbits * CLKS + 3; c++) begin
      if (c % CLKS == 5 && c / CLKS < nbits) bits[c / CLKS] = sel ? txd_b : txd;
      if (sel ? done_b : done) begin
        if (done_cnt == 0) done_cyc = c;
        done_cnt++;
      end
      if (c == nbits * CLKS) busy_after = sel ? busy_b : busy;
      @(negedge clk);
    end
  endtask

  task automatic literal_frame(input string tag, input bit sel, input logic [8:0] w,
                               input int nbits, input logic [15:0] exp_bits);
    logic [15:0] bits;
    int lat, lvl, dc, dn;
    logic bs, ba;
    send_capture(sel, w, nbits, bits, lat, lvl, dc, dn, bs, ba);
    check({tag, "_latency"}, lat, 2);
    check({tag, "_level_after_accept"}, lvl, 1);
    check({tag, "_bits"}, bits, exp_bits);
    check({tag, "_done_cycle"}, dc, nbits * CLKS - 1);
    check({tag, "_done_count"}, dn, 1);
    check({tag, "_busy_at_start"}, bs, 1);
    check({tag, "_busy_after"}, ba, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, n, busy_cnt, done_cnt, low_cnt;
    bit saw_full;
    logic [7:0] words [5];

    @(posedge clk);
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_txd", txd, 1);
    check("reset_ready", ready, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_level", level, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    literal_frame("a55", 1'b0, 9'h055, NBITS, 16'h0CAA);
    literal_frame("a57", 1'b0, 9'h057, NBITS, 16'h0EAE);

    words[0] = 8'h41; words[1] = 8'h42; words[2] = 8'h43; words[3] = 8'h44; words[4] = 8'h45;
    idx = 0; busy_cnt = 0; done_cnt = 0; saw_full = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (!ready) saw_full = 1'b1;
      if (busy_cnt > 0 && !busy) break;
      if (idx < 5) begin
        valid = 1'b1;
        if (ready) begin data = words[idx]; idx++; end
        else data = 8'($urandom);
      end else valid = 1'b0;
    end
    valid = 1'b0;
    check("burst_busy_cycles", busy_cnt, 5 * FL);
    check("burst_done_pulses", done_cnt, 5);
    check("burst_ready_dropped", saw_full, 1);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c % 1000 < 150) valid = 1'b1;
      else if (c % 1000 < 350) valid = ($urandom_range(0, 7) == 0);
      else valid = 1'b0;
      data = 8'($urandom);
    end
    valid = 1'b0;
    n = 0;
    while (!(level == 0 && !busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", (n < 2000), 1);

    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      valid = 1'b1; data = 8'($urandom);
    end
    @(negedge clk);
    valid = 1'b0;
    n = 0;
    while (txd && n < 20) begin @(negedge clk); n++; end
    check("midreset_frame_started", (n < 20), 1);
    repeat (35) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_txd", txd, 1);
    check("midreset_level", level, 0);
    check("midreset_ready", ready, 1);
    check("midreset_busy", busy, 0);
    rst_n = 1'b1;
    low_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 250; c++) begin
      @(negedge clk);
      if (!txd) low_cnt++;
      if (done) done_cnt++;
    end
    check("postreset_txd_low_cycles", low_cnt, 0);
    check("postreset_done_pulses", done_cnt, 0);

    literal_frame("b07_odd", 1'b1, 9'h007, 10, 16'h020E);
    literal_frame("b55_odd", 1'b1, 9'h055, 10, 16'h03AA);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
